// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the 68010 bus arbitration responder.
// Holds the FSM state encoding and the default parameter values.
package cpu_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CYC = 3'd1,
    ST_GRANT    = 3'd2,
    ST_OWNED    = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TMO_W_DEF       = 10;
  localparam int unsigned TMO_LIMIT_DEF   = 1000;

endpackage

// File: rtl/cpu_bus_arbiter_bus_sync.sv
// N-stage synchronizer for an asynchronous active-low bus signal.
// Resets to 1 so that a held-off request never appears asserted.
module bus_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU-side 68010 bus arbitration responder: answers /BR with /BG, tracks /BGACK
// ownership, stalls the core while another master holds the bus, and runs a DMA watchdog.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TMO_W       = TMO_W_DEF,
  parameter int unsigned TMO_LIMIT   = TMO_LIMIT_DEF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       BR_n,
  input  logic       BGACK_n,
  input  logic       AS_n,
  input  logic       CPU_CYC_ACTIVE,
  input  logic       CLR_TMO,
  output logic       BG_n,
  output logic       CPU_HOLD,
  output logic       TIMEOUT,
  output logic       TMO_STICKY,
  output logic [2:0] STATE
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TMO_LIMIT);

  arb_state_e       state;
  arb_state_e       nxt;
  logic             br_sync_n;
  logic             bgack_sync_n;
  logic             br;
  logic             bgack;
  logic [TMO_W-1:0] tmo_cnt;

  bus_sync #(.STAGES(SYNC_STAGES)) u_br_sync (
    .clk   (CLK),
    .rst_n (RESET_n),
    .d     (BR_n),
    .q     (br_sync_n)
  );

  bus_sync #(.STAGES(SYNC_STAGES)) u_bgack_sync (
    .clk   (CLK),
    .rst_n (RESET_n),
    .d     (BGACK_n),
    .q     (bgack_sync_n)
  );

  assign br    = ~br_sync_n;
  assign bgack = ~bgack_sync_n;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (bgack)   nxt = ST_OWNED;
        else if (br) nxt = CPU_CYC_ACTIVE ? ST_WAIT_CYC : ST_GRANT;
      end
      ST_WAIT_CYC: begin
        if (!br)                          nxt = ST_IDLE;
        else if (bgack)                   nxt = ST_OWNED;
        else if (!CPU_CYC_ACTIVE && AS_n) nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (bgack)    nxt = ST_OWNED;
        else if (!br) nxt = ST_IDLE;
      end
      ST_OWNED: begin
        if (!bgack) nxt = br ? ST_GRANT : ST_RELEASE;
      end
      ST_RELEASE: nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from nxt so they settle on the same edge as the state.
  // The watchdog is zero whenever the previous cycle was outside OWNED, which
  // clears it on every entry; it saturates so TIMEOUT fires once per ownership.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= ST_IDLE;
      BG_n       <= 1'b1;
      CPU_HOLD   <= 1'b0;
      TIMEOUT    <= 1'b0;
      TMO_STICKY <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state    <= nxt;
      BG_n     <= (nxt != ST_GRANT);
      CPU_HOLD <= (nxt != ST_IDLE);
      if (state != ST_OWNED)     tmo_cnt <= '0;
      else if (tmo_cnt != TMO_SAT) tmo_cnt <= tmo_cnt + 1'b1;
      TIMEOUT    <= (state == ST_OWNED) && (tmo_cnt == TMO_LAST);
      TMO_STICKY <= TIMEOUT | (TMO_STICKY & ~CLR_TMO);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level reference model of the arbitration rules.
module tb_cpu_bus_arbiter;

  localparam int S     = 2;
  localparam int LIMIT = 8;
  localparam int IDLE = 0, WAIT_CYC = 1, GRANT = 2, OWNED = 3, RELEASE = 4;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b1;
  logic       BR_n = 1'b1, BGACK_n = 1'b1, AS_n = 1'b1;
  logic       CPU_CYC_ACTIVE = 1'b0, CLR_TMO = 1'b0;
  logic       BG_n, CPU_HOLD, TIMEOUT, TMO_STICKY;
  logic [2:0] STATE;

  int n_vec = 0;
  int n_err = 0;

  cpu_bus_arbiter #(.SYNC_STAGES(S), .TMO_W(10), .TMO_LIMIT(LIMIT)) dut (
    .CLK            (CLK),
    .RESET_n        (RESET_n),
    .BR_n           (BR_n),
    .BGACK_n        (BGACK_n),
    .AS_n           (AS_n),
    .CPU_CYC_ACTIVE (CPU_CYC_ACTIVE),
    .CLR_TMO        (CLR_TMO),
    .BG_n           (BG_n),
    .CPU_HOLD       (CPU_HOLD),
    .TIMEOUT        (TIMEOUT),
    .TMO_STICKY     (TMO_STICKY),
    .STATE          (STATE)
  );

  always #5 CLK = ~CLK;

  // Reference model: raw input history stands in for the synchronizers,
  // and the watchdog is the length of the current run of OWNED cycles.
  int m_st, m_run;
  bit m_bg_n, m_hold, m_to, m_sticky;
  bit br_hist[$];
  bit bgack_hist[$];

  task automatic model_reset();
    m_st = IDLE; m_run = 0; m_bg_n = 1; m_hold = 0; m_to = 0; m_sticky = 0;
    br_hist = {}; bgack_hist = {};
    repeat (S) begin br_hist.push_back(1'b1); bgack_hist.push_back(1'b1); end
  endtask

  task automatic model_edge();
    bit br, bgack;
    int nx;
    br    = !br_hist[0];
    bgack = !bgack_hist[0];
    void'(br_hist.pop_front());    br_hist.push_back(BR_n);
    void'(bgack_hist.pop_front()); bgack_hist.push_back(BGACK_n);
    nx = m_st;
    case (m_st)
      IDLE:     if (bgack) nx = OWNED; else if (br) nx = CPU_CYC_ACTIVE ? WAIT_CYC : GRANT;
      WAIT_CYC: if (!br) nx = IDLE; else if (bgack) nx = OWNED;
                else if (!CPU_CYC_ACTIVE && AS_n) nx = GRANT;
      GRANT:    if (bgack) nx = OWNED; else if (!br) nx = IDLE;
      OWNED:    if (!bgack) nx = br ? GRANT : RELEASE;
      default:  nx = IDLE;
    endcase
    m_run = (m_st == OWNED) ? m_run + 1 : 0;
    if (m_run > LIMIT + 1) m_run = LIMIT + 1;
    m_sticky = m_to || (m_sticky && !CLR_TMO);
    m_to     = (m_st == OWNED) && (m_run == LIMIT);
    m_st     = nx;
    m_bg_n   = (nx != GRANT);
    m_hold   = (nx != IDLE);
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RESET_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic do_reset();
    BR_n = 1; BGACK_n = 1; AS_n = 1; CPU_CYC_ACTIVE = 0; CLR_TMO = 0;
    RESET_n = 1; #1; RESET_n = 0;
    step(); step();
    RESET_n = 1;
  endtask

  task automatic test_reset();
    BR_n = 0; BGACK_n = 0;
    RESET_n = 1; #1; RESET_n = 0; #1;
    n_vec++; if (BG_n !== 1'b1) begin n_err++; $display("FAIL rst_bg: BG_n=%b expected 1", BG_n); end
    n_vec++; if (CPU_HOLD !== 1'b0) begin n_err++; $display("FAIL rst_hold: CPU_HOLD=%b expected 0", CPU_HOLD); end
    step(); step();
    n_vec++; if (STATE !== 3'd0) begin n_err++; $display("FAIL rst_state: STATE=%0d expected 0", STATE); end
    n_vec++; if (TIMEOUT !== 1'b0 || TMO_STICKY !== 1'b0) begin
      n_err++; $display("FAIL rst_tmo: TIMEOUT=%b TMO_STICKY=%b expected 0 0", TIMEOUT, TMO_STICKY);
    end
    n_vec++; if (BG_n !== 1'b1) begin n_err++; $display("FAIL rst_bg_held: BG_n=%b expected 1", BG_n); end
    do_reset();
  endtask

  task automatic test_grant_latency();
    do_reset();
    BR_n = 0;
    step(); step();
    n_vec++; if (BG_n !== 1'b1) begin n_err++; $display("FAIL t1_bg_early: BG_n=%b expected 1", BG_n); end
    step();
    n_vec++; if (BG_n !== 1'b0 || STATE !== 3'd2) begin
      n_err++; $display("FAIL t1_bg_grant: BG_n=%b STATE=%0d expected 0 2", BG_n, STATE);
    end
    BGACK_n = 0; BR_n = 1;
    step(); step();
    n_vec++; if (BG_n !== 1'b0) begin n_err++; $display("FAIL t1_bg_hold: BG_n=%b expected 0", BG_n); end
    step();
    n_vec++; if (BG_n !== 1'b1 || STATE !== 3'd3 || CPU_HOLD !== 1'b1) begin
      n_err++; $display("FAIL t1_owned: BG_n=%b STATE=%0d CPU_HOLD=%b expected 1 3 1", BG_n, STATE, CPU_HOLD);
    end
    repeat (2) step();
    BGACK_n = 1;
    step(); step();
    n_vec++; if (CPU_HOLD !== 1'b1 || STATE !== 3'd3) begin
      n_err++; $display("FAIL t1_still_owned: CPU_HOLD=%b STATE=%0d expected 1 3", CPU_HOLD, STATE);
    end
    step();
    n_vec++; if (CPU_HOLD !== 1'b1 || STATE !== 3'd4) begin
      n_err++; $display("FAIL t1_release: CPU_HOLD=%b STATE=%0d expected 1 4", CPU_HOLD, STATE);
    end
    step();
    n_vec++; if (CPU_HOLD !== 1'b0 || STATE !== 3'd0) begin
      n_err++; $display("FAIL t1_idle: CPU_HOLD=%b STATE=%0d expected 0 0", CPU_HOLD, STATE);
    end
  endtask

  task automatic test_wait_cycle();
    do_reset();
    CPU_CYC_ACTIVE = 1; AS_n = 0; BR_n = 0;
    repeat (3) step();
    n_vec++; if (STATE !== 3'd1 || CPU_HOLD !== 1'b1 || BG_n !== 1'b1) begin
      n_err++; $display("FAIL t2_wait: STATE=%0d CPU_HOLD=%b BG_n=%b expected 1 1 1", STATE, CPU_HOLD, BG_n);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) CPU_CYC_ACTIVE = 0;
      step();
      n_vec++; if (BG_n !== 1'b1) begin n_err++; $display("FAIL t2_bg_blocked: cyc %0d BG_n=%b expected 1", i, BG_n); end
    end
    AS_n = 1;
    step();
    n_vec++; if (BG_n !== 1'b0 || STATE !== 3'd2) begin
      n_err++; $display("FAIL t2_grant: BG_n=%b STATE=%0d expected 0 2", BG_n, STATE);
    end
  endtask

  task automatic test_grant_withdrawn();
    BR_n = 1;
    step(); step();
    n_vec++; if (STATE !== 3'd2) begin n_err++; $display("FAIL t3_grant_held: STATE=%0d expected 2", STATE); end
    step();
    n_vec++; if (STATE !== 3'd0 || BG_n !== 1'b1 || CPU_HOLD !== 1'b0) begin
      n_err++; $display("FAIL t3_withdrawn: STATE=%0d BG_n=%b CPU_HOLD=%b expected 0 1 0", STATE, BG_n, CPU_HOLD);
    end
  endtask

  task automatic test_timeout();
    int pulses, first, waited;
    bit seen;
    do_reset();
    BR_n = 0;
    repeat (3) step();
    BGACK_n = 0; BR_n = 1;
    pulses = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (TIMEOUT === 1'b1) begin pulses++; if (first < 0) first = i; end
      n_vec++; if (TIMEOUT !== m_to) begin n_err++; $display("FAIL t4_pulse: cyc %0d TIMEOUT=%b expected %b", i, TIMEOUT, m_to); end
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL t4_count: pulses=%0d expected 1", pulses); end
    n_vec++; if (first != S + 1 + LIMIT) begin n_err++; $display("FAIL t4_when: cyc=%0d expected %0d", first, S + 1 + LIMIT); end
    n_vec++; if (TMO_STICKY !== 1'b1) begin n_err++; $display("FAIL t4_sticky: TMO_STICKY=%b expected 1", TMO_STICKY); end
    CLR_TMO = 1; step(); CLR_TMO = 0;
    n_vec++; if (TMO_STICKY !== 1'b0) begin n_err++; $display("FAIL t4_clear: TMO_STICKY=%b expected 0", TMO_STICKY); end
    BGACK_n = 1;
    repeat (4) step();
    BR_n = 0;
    repeat (3) step();
    BGACK_n = 0; BR_n = 1;
    seen = 0; waited = 0;
    while (!seen && waited < 30) begin step(); waited++; seen = (TIMEOUT === 1'b1); end
    n_vec++; if (!seen) begin n_err++; $display("FAIL t4_second: TIMEOUT=%b expected 1 within 30 clks", TIMEOUT); end
    CLR_TMO = 1; step(); CLR_TMO = 0;
    n_vec++; if (TMO_STICKY !== 1'b1) begin n_err++; $display("FAIL t4_set_wins: TMO_STICKY=%b expected 1", TMO_STICKY); end
    BGACK_n = 1;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    BR_n = 0;
    repeat (3) step();
    BGACK_n = 0;
    repeat (3) step();
    n_vec++; if (STATE !== 3'd3) begin n_err++; $display("FAIL t5_owned: STATE=%0d expected 3", STATE); end
    repeat (2) step();
    BGACK_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (STATE === 3'd4) begin n_err++; $display("FAIL t5_no_release: cyc %0d STATE=%0d expected not 4", i, STATE); end
    end
    n_vec++; if (STATE !== 3'd2 || BG_n !== 1'b0) begin
      n_err++; $display("FAIL t5_regrant: STATE=%0d BG_n=%b expected 2 0", STATE, BG_n);
    end
    BR_n = 1;
    repeat (4) step();
  endtask

  task automatic test_async_reset();
    do_reset();
    BR_n = 0;
    repeat (3) step();
    BGACK_n = 0; BR_n = 1;
    repeat (14) step();
    n_vec++; if (TMO_STICKY !== 1'b1 || CPU_HOLD !== 1'b1) begin
      n_err++; $display("FAIL t6_pre: TMO_STICKY=%b CPU_HOLD=%b expected 1 1", TMO_STICKY, CPU_HOLD);
    end
    #2; RESET_n = 0; #1;
    n_vec++; if (BG_n !== 1'b1 || CPU_HOLD !== 1'b0 || TMO_STICKY !== 1'b0 || STATE !== 3'd0) begin
      n_err++; $display("FAIL t6_async: BG_n=%b CPU_HOLD=%b TMO_STICKY=%b STATE=%0d expected 1 0 0 0",
                        BG_n, CPU_HOLD, TMO_STICKY, STATE);
    end
    model_reset();
    BGACK_n = 1;
    step();
    RESET_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0)  BR_n = ~BR_n;
      if ($urandom_range(9) == 0)  BGACK_n = ~BGACK_n;
      CPU_CYC_ACTIVE = ($urandom_range(2) == 0);
      AS_n           = ($urandom_range(1) == 0);
      CLR_TMO        = ($urandom_range(15) == 0);
      step();
      n_vec++;
      if (BG_n !== m_bg_n || CPU_HOLD !== m_hold || STATE !== 3'(m_st) ||
          TIMEOUT !== m_to || TMO_STICKY !== m_sticky) begin
        n_err++;
        $display("FAIL rand: cyc %0d got BG_n=%b HOLD=%b ST=%0d TO=%b STK=%b expected %b %b %0d %b %b",
                 i, BG_n, CPU_HOLD, STATE, TIMEOUT, TMO_STICKY, m_bg_n, m_hold, m_st, m_to, m_sticky);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_grant_latency();
    test_wait_cycle();
    test_grant_withdrawn();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
